// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control-word width, field positions and small field helpers.
// Control word layout: {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp[3:0]}.
package id_ex_stage_pkg;

  localparam int ALUOP_WIDTH   = 4;
  localparam int CTRL_WIDTH    = 6 + ALUOP_WIDTH;

  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUOP_HI = ALUOP_WIDTH - 1;
  localparam int CTRL_ALUOP_LO = 0;

  function automatic logic ctrlIsLoad(input logic [CTRL_WIDTH-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/id_bypass_mux.sv
// Operand select for one register-file read port: forwards same-cycle writeback data
// and forces the hardwired zero register when enabled.
module id_bypass_mux
  import id_ex_stage_pkg::*;
#(
  parameter int REG_SELECT_WIDTH = 5,
  parameter int DATA_WIDTH       = 32,
  parameter bit ZERO_REG_EN      = 1'b1
) (
  input  logic [REG_SELECT_WIDTH-1:0] ReadSelect,
  input  logic [DATA_WIDTH-1:0]       ReadData,
  input  logic [REG_SELECT_WIDTH-1:0] WriteSelect,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  input  logic                        WriteEnable,
  output logic [DATA_WIDTH-1:0]       Operand
);

  logic isZeroReg_s;

  // Zero register wins over any writeback aimed at it.
  always_comb begin
    isZeroReg_s = ZERO_REG_EN && (ReadSelect == '0);
    if (isZeroReg_s) begin
      Operand = '0;
    end else if (WriteEnable && (WriteSelect == ReadSelect)) begin
      Operand = WriteData;
    end else begin
      Operand = ReadData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use hazard detection,
// bubble insertion and a saturating hazard-bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int REG_SELECT_WIDTH = 5,
  parameter int DATA_WIDTH       = 32,
  parameter bit ZERO_REG_EN      = 1'b1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DATA_WIDTH-1:0]       ReadData1,
  input  logic [DATA_WIDTH-1:0]       ReadData2,
  input  logic [REG_SELECT_WIDTH-1:0] ReadSelect1,
  input  logic [REG_SELECT_WIDTH-1:0] ReadSelect2,
  input  logic [REG_SELECT_WIDTH-1:0] IdRd,
  input  logic                        IdUsesRt,
  input  logic [DATA_WIDTH-1:0]       IdImm,
  input  logic [CTRL_WIDTH-1:0]       IdCtrl,
  input  logic                        IdValid,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  input  logic [REG_SELECT_WIDTH-1:0] WriteSelect,
  input  logic                        WriteEnable,
  input  logic                        Stall,
  input  logic                        Flush,
  output logic                        HazardStall,
  output logic [DATA_WIDTH-1:0]       ExA,
  output logic [DATA_WIDTH-1:0]       ExB,
  output logic [DATA_WIDTH-1:0]       ExImm,
  output logic [REG_SELECT_WIDTH-1:0] ExRs,
  output logic [REG_SELECT_WIDTH-1:0] ExRt,
  output logic [REG_SELECT_WIDTH-1:0] ExRd,
  output logic [CTRL_WIDTH-1:0]       ExCtrl,
  output logic                        ExValid,
  output logic [CNT_WIDTH-1:0]        BubbleCount
);

  logic [DATA_WIDTH-1:0]       opA_s, opB_s;
  logic                        hazard_s;
  logic [DATA_WIDTH-1:0]       exA_r, exB_r, exImm_r;
  logic [REG_SELECT_WIDTH-1:0] exRs_r, exRt_r, exRd_r;
  logic [CTRL_WIDTH-1:0]       exCtrl_r;
  logic                        exValid_r;
  logic [CNT_WIDTH-1:0]        bubbleCount_r;

  id_bypass_mux #(
    .REG_SELECT_WIDTH(REG_SELECT_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)
  ) uBypassA (
    .ReadSelect(ReadSelect1), .ReadData(ReadData1), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .WriteEnable(WriteEnable), .Operand(opA_s)
  );

  id_bypass_mux #(
    .REG_SELECT_WIDTH(REG_SELECT_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ZERO_REG_EN(ZERO_REG_EN)
  ) uBypassB (
    .ReadSelect(ReadSelect2), .ReadData(ReadData2), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .WriteEnable(WriteEnable), .Operand(opB_s)
  );

  // Load-use check against the load currently in EX; zero latency so IF/ID can hold now.
  always_comb begin
    hazard_s = exValid_r && ctrlIsLoad(exCtrl_r) && (exRt_r != '0) && IdValid &&
               ((exRt_r == ReadSelect1) || (IdUsesRt && (exRt_r == ReadSelect2)));
  end

  // Pipeline register update: Reset > Flush > Stall > hazard bubble > load.
  always_ff @(posedge Clk) begin
    if (Reset || Flush || (!Stall && hazard_s)) begin
      exA_r     <= '0;
      exB_r     <= '0;
      exImm_r   <= '0;
      exRs_r    <= '0;
      exRt_r    <= '0;
      exRd_r    <= '0;
      exCtrl_r  <= '0;
      exValid_r <= 1'b0;
    end else if (Stall) begin
      exA_r     <= exA_r;
      exValid_r <= exValid_r;
    end else begin
      exA_r     <= opA_s;
      exB_r     <= opB_s;
      exImm_r   <= IdImm;
      exRs_r    <= ReadSelect1;
      exRt_r    <= ReadSelect2;
      exRd_r    <= IdRd;
      exCtrl_r  <= IdValid ? IdCtrl : '0;
      exValid_r <= IdValid;
    end
  end

  // Bubble counter only counts hazard bubbles that are not masked by Flush or Stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubbleCount_r <= '0;
    end else if (!Flush && !Stall && hazard_s && (bubbleCount_r != '1)) begin
      bubbleCount_r <= bubbleCount_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      bubbleCount_r <= bubbleCount_r;
    end
  end

  assign HazardStall = hazard_s;
  assign ExA         = exA_r;
  assign ExB         = exB_r;
  assign ExImm       = exImm_r;
  assign ExRs        = exRs_r;
  assign ExRt        = exRt_r;
  assign ExRd        = exRd_r;
  assign ExCtrl      = exCtrl_r;
  assign ExValid     = exValid_r;
  assign BubbleCount = bubbleCount_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic against
// a cycle-level behavioural model of the stage.
module tb_id_ex_stage;

  localparam int RSW = 5;
  localparam int DW  = 32;
  localparam int CW  = 10;
  localparam int CNT = 8;
  localparam int CNT_MAX = (1 << CNT) - 1;
  localparam logic [CW-1:0] LW_CTRL  = 10'h360;
  localparam logic [CW-1:0] ADD_CTRL = 10'h201;

  logic           Clk = 1'b0;
  logic           Reset, IdUsesRt, IdValid, WriteEnable, Stall, Flush;
  logic [DW-1:0]  ReadData1, ReadData2, IdImm, WriteData;
  logic [RSW-1:0] ReadSelect1, ReadSelect2, IdRd, WriteSelect;
  logic [CW-1:0]  IdCtrl;
  logic           HazardStall, ExValid;
  logic [DW-1:0]  ExA, ExB, ExImm;
  logic [RSW-1:0] ExRs, ExRt, ExRd;
  logic [CW-1:0]  ExCtrl;
  logic [CNT-1:0] BubbleCount;

  // Model of the EX slot contents and bubble count
  logic [DW-1:0]  mA, mB, mImm;
  logic [RSW-1:0] mRs, mRt, mRd;
  logic [CW-1:0]  mCtrl;
  logic           mValid;
  int             mCount;
  logic           lastHz;

  int checkCount = 0;
  int errCount   = 0;

  id_ex_stage #(.REG_SELECT_WIDTH(RSW), .DATA_WIDTH(DW), .ZERO_REG_EN(1'b1), .CNT_WIDTH(CNT)) dut (
    .Clk(Clk), .Reset(Reset), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2), .IdRd(IdRd), .IdUsesRt(IdUsesRt),
    .IdImm(IdImm), .IdCtrl(IdCtrl), .IdValid(IdValid), .WriteData(WriteData),
    .WriteSelect(WriteSelect), .WriteEnable(WriteEnable), .Stall(Stall), .Flush(Flush),
    .HazardStall(HazardStall), .ExA(ExA), .ExB(ExB), .ExImm(ExImm), .ExRs(ExRs), .ExRt(ExRt),
    .ExRd(ExRd), .ExCtrl(ExCtrl), .ExValid(ExValid), .BubbleCount(BubbleCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register-file read seen by EX: zero register reads 0, a same-cycle write is forwarded
  function automatic logic [DW-1:0] expOperand(input logic [RSW-1:0] sel, input logic [DW-1:0] rd);
    if (sel == 5'd0) return 32'd0;
    if (WriteEnable && (WriteSelect == sel)) return WriteData;
    return rd;
  endfunction

  task automatic checkAll();
    checkVal("ExA", ExA, mA);
    checkVal("ExB", ExB, mB);
    checkVal("ExImm", ExImm, mImm);
    checkVal("ExRs", {27'd0, ExRs}, {27'd0, mRs});
    checkVal("ExRt", {27'd0, ExRt}, {27'd0, mRt});
    checkVal("ExRd", {27'd0, ExRd}, {27'd0, mRd});
    checkVal("ExCtrl", {22'd0, ExCtrl}, {22'd0, mCtrl});
    checkVal("ExValid", {31'd0, ExValid}, {31'd0, mValid});
    checkVal("BubbleCount", {24'd0, BubbleCount}, mCount);
  endtask

  // One clock: check the combinational hazard, advance the model, check the registers
  task automatic step();
    logic hz;
    logic bubble;
    #1;
    hz = mValid && mCtrl[8] && (mRt != 5'd0) && IdValid &&
         ((mRt == ReadSelect1) || (IdUsesRt && (mRt == ReadSelect2)));
    lastHz = hz;
    checkVal("HazardStall", {31'd0, HazardStall}, {31'd0, hz});
    bubble = Reset || Flush || (!Stall && hz);
    @(posedge Clk);
    if (Reset) mCount = 0;
    else if (!Flush && !Stall && hz && mCount < CNT_MAX) mCount = mCount + 1;
    if (bubble) begin
      mA = 0; mB = 0; mImm = 0; mRs = 0; mRt = 0; mRd = 0; mCtrl = 0; mValid = 0;
    end else if (!Stall) begin
      mA = expOperand(ReadSelect1, ReadData1);
      mB = expOperand(ReadSelect2, ReadData2);
      mImm = IdImm; mRs = ReadSelect1; mRt = ReadSelect2; mRd = IdRd;
      mCtrl = IdValid ? IdCtrl : '0;
      mValid = IdValid;
    end
    #1;
    checkAll();
  endtask

  task automatic randomId();
    ReadData1   = $urandom;
    ReadData2   = $urandom;
    ReadSelect1 = 5'($urandom_range(0, 3));
    ReadSelect2 = 5'($urandom_range(0, 3));
    IdRd        = 5'($urandom);
    IdUsesRt    = 1'($urandom);
    IdImm       = $urandom;
    IdCtrl      = 10'($urandom);
    IdValid     = ($urandom_range(0, 3) != 0);
    WriteData   = $urandom;
    WriteSelect = 5'($urandom_range(0, 3));
    WriteEnable = 1'($urandom);
  endtask

  task automatic setId(input logic [RSW-1:0] rs, input logic [RSW-1:0] rt, input logic usesRt,
                       input logic [CW-1:0] ctrl);
    ReadSelect1 = rs; ReadSelect2 = rt; IdUsesRt = usesRt; IdCtrl = ctrl; IdValid = 1'b1;
    WriteEnable = 1'b0; Stall = 1'b0; Flush = 1'b0; Reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] heldA;
    logic [CW-1:0] heldCtrl;
    int heldCount;
    mA = 0; mB = 0; mImm = 0; mRs = 0; mRt = 0; mRd = 0; mCtrl = 0; mValid = 0; mCount = 0;
    lastHz = 1'b0;
    // 1. Reset with nonzero inputs
    randomId();
    IdValid = 1'b1; IdCtrl = LW_CTRL; Stall = 1'b0; Flush = 1'b0; Reset = 1'b1;
    @(posedge Clk);
    step();
    step();
    checkVal("rstExValid", {31'd0, ExValid}, 32'd0);
    checkVal("rstBubble", {24'd0, BubbleCount}, 32'd0);
    checkVal("rstHazard", {31'd0, HazardStall}, 32'd0);
    // 2. Writeback bypass, then zero register never bypassed
    setId(5'd5, 5'd1, 1'b0, ADD_CTRL);
    WriteEnable = 1'b1; WriteSelect = 5'd5; WriteData = 32'hDEADBEEF; ReadData1 = 32'h11;
    step();
    checkVal("bypassA", ExA, 32'hDEADBEEF);
    ReadSelect1 = 5'd0; WriteSelect = 5'd0;
    step();
    checkVal("zeroRegA", ExA, 32'd0);
    // 3. Load-use hazard on rt: bubble, then held instruction loads
    setId(5'd2, 5'd8, 1'b0, LW_CTRL);
    step();
    setId(5'd3, 5'd8, 1'b1, ADD_CTRL);
    step();
    checkVal("hzDetect", {31'd0, lastHz}, 32'd1);
    checkVal("hzBubbleValid", {31'd0, ExValid}, 32'd0);
    checkVal("hzBubbleCtrl", {22'd0, ExCtrl}, 32'd0);
    checkVal("hzCount", {24'd0, BubbleCount}, 32'd1);
    step();
    checkVal("hzReleased", {31'd0, lastHz}, 32'd0);
    checkVal("hzHeldLoad", {22'd0, ExCtrl}, {22'd0, ADD_CTRL});
    // 4. No hazard when rt unused, or when the load targets register 0
    setId(5'd2, 5'd8, 1'b0, LW_CTRL);
    step();
    setId(5'd3, 5'd8, 1'b0, ADD_CTRL);
    step();
    checkVal("noHzUnusedRt", {31'd0, lastHz}, 32'd0);
    setId(5'd2, 5'd0, 1'b0, LW_CTRL);
    step();
    setId(5'd0, 5'd0, 1'b1, ADD_CTRL);
    step();
    checkVal("noHzZeroRt", {31'd0, lastHz}, 32'd0);
    // 5. Stall holds, Flush beats Stall, Flush masks a hazard's count
    heldA = ExA; heldCtrl = ExCtrl;
    for (int i = 0; i < 3; i++) begin
      randomId();
      Stall = 1'b1; Flush = 1'b0; Reset = 1'b0;
      step();
      checkVal("stallHoldA", ExA, heldA);
      checkVal("stallHoldCtrl", {22'd0, ExCtrl}, {22'd0, heldCtrl});
    end
    setId(5'd1, 5'd2, 1'b1, ADD_CTRL);
    Stall = 1'b1; Flush = 1'b1;
    step();
    checkVal("flushStallValid", {31'd0, ExValid}, 32'd0);
    setId(5'd2, 5'd8, 1'b0, LW_CTRL);
    step();
    heldCount = BubbleCount;
    setId(5'd8, 5'd1, 1'b0, ADD_CTRL);
    Flush = 1'b1;
    step();
    checkVal("flushHzSeen", {31'd0, lastHz}, 32'd1);
    checkVal("flushHzValid", {31'd0, ExValid}, 32'd0);
    checkVal("flushHzCount", {24'd0, BubbleCount}, heldCount);
    // 6. Saturation: a load that depends on itself bubbles every other cycle
    Reset = 1'b1;
    step();
    setId(5'd8, 5'd8, 1'b1, LW_CTRL);
    for (int i = 0; i < 2 * (CNT_MAX + 3) + 2; i++) step();
    checkVal("bubbleSaturate", {24'd0, BubbleCount}, CNT_MAX);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      randomId();
      Stall = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Reset = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
